matrix_scroller: RTL and testbench

MATRIX_SCROLLER -- requirements
Module: matrix_scroller

---
 rtl/led_pkg.sv | 22 ++
 rtl/step_timer.sv | 39 +++
 rtl/matrix_scroller.sv | 192 +++++++++++++++++++
 tb/tb_matrix_scroller.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED matrix scroller.
//   MATRIX_DIM       : rows and columns of the physical LED matrix
//   DEFAULT_BUF_COLS : default depth of the scroller column buffer
//   scroll_state_t   : scroller control states
//   column_t         : one matrix column, bit k = row k
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int unsigned MATRIX_DIM       = 8;
    localparam int unsigned DEFAULT_BUF_COLS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HOLD = 2'd2
    } scroll_state_t;

    typedef logic [MATRIX_DIM-1:0] column_t;

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Scroll-step prescaler. Counts 0..STEP_DIV-1 while enabled and flags the
// terminal count so the scroller advances one column per STEP_DIV clocks.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   enable : count while high
//   clear  : force the count back to zero (wins over enable)
//   tc     : high for the cycle in which the count sits at STEP_DIV-1
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int unsigned STEP_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tc
);

    localparam int unsigned        CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tc = enable && (count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_scroller.sv
// -----------------------------------------------------------------------------
// matrix_scroller
// Column buffer plus scroll engine for an 8x8 red/green LED matrix. Columns
// are loaded while idle, then an 8-column window slides across the buffer
// one column per STEP_DIV clocks, either once (ending in a frozen frame) or
// wrapping forever.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   wr_valid / wr_ready : column write handshake (accepted only while idle)
//   wr_col_r, wr_col_g  : red / green column, bit k = row k
//   start, loop         : begin display; loop sampled with start
//   stop                : return to idle, buffer kept
//   clr                 : empty the buffer (idle only)
//   busy                : showing or holding a frame
//   frame_done          : one-cycle pulse when a one-shot pass ends
//   matrix_r, matrix_g  : frame for the matrix driver, byte r = row r,
//                         window column 0 in the MSB of each row byte
// -----------------------------------------------------------------------------
module matrix_scroller
    import led_pkg::*;
#(
    parameter int unsigned STEP_DIV = 12_500_000,
    parameter int unsigned BUF_COLS = DEFAULT_BUF_COLS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [MATRIX_DIM-1:0]            wr_col_r,
    input  logic [MATRIX_DIM-1:0]            wr_col_g,
    input  logic                             start,
    input  logic                             loop,
    input  logic                             stop,
    input  logic                             clr,
    output logic                             busy,
    output logic                             frame_done,
    output logic [MATRIX_DIM*MATRIX_DIM-1:0] matrix_r,
    output logic [MATRIX_DIM*MATRIX_DIM-1:0] matrix_g
);

    localparam int unsigned      LEN_W    = $clog2(BUF_COLS + 1);
    localparam int unsigned      OFS_W    = $clog2(BUF_COLS);
    localparam int unsigned      SUM_W    = $clog2(BUF_COLS + MATRIX_DIM);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BUF_COLS);
    localparam logic [LEN_W-1:0] LEN_WIN  = LEN_W'(MATRIX_DIM);

    scroll_state_t    state, next_state;
    logic [LEN_W-1:0] len, len_base, len_next;
    logic [OFS_W-1:0] offset;
    logic             loop_q;
    logic             wr_fire;
    logic             step;
    logic             show_start, step_advance, step_wrap, enter_hold;

    column_t buf_r [BUF_COLS];
    column_t buf_g [BUF_COLS];
    column_t win_r [MATRIX_DIM];
    column_t win_g [MATRIX_DIM];

    logic [MATRIX_DIM*MATRIX_DIM-1:0] frame_r, frame_g;

    assign wr_ready = (state == ST_IDLE) && (len < LEN_FULL);
    assign wr_fire  = wr_valid && wr_ready;

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state == ST_SHOW),
        .clear  (state != ST_SHOW),
        .tc     (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        next_state   = state;
        show_start   = 1'b0;
        step_advance = 1'b0;
        step_wrap    = 1'b0;
        enter_hold   = 1'b0;
        // A same-cycle clear empties the buffer before a write lands, so the
        // write becomes column 0; start then sees the resulting length.
        len_base     = clr ? '0 : len;
        len_next     = wr_fire ? len_base + LEN_W'(1) : len_base;

        unique case (state)
            ST_IDLE: begin
                if (start && (len_next != '0)) begin
                    next_state = ST_SHOW;
                    show_start = 1'b1;
                end
            end
            ST_SHOW: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else if (step && (len > LEN_WIN)) begin
                    // One-shot ends once the last column is already in view.
                    if (!loop_q && (LEN_W'(offset) == len - LEN_WIN)) begin
                        next_state = ST_HOLD;
                        enter_hold = 1'b1;
                    end else begin
                        step_advance = 1'b1;
                        step_wrap    = (LEN_W'(offset) == len - LEN_W'(1));
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else if (start) begin
                    next_state = ST_SHOW;
                    show_start = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: the column store is deliberately left out of reset; len alone
    // decides which entries are meaningful, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            buf_r[OFS_W'(len_base)] <= wr_col_r;
            buf_g[OFS_W'(len_base)] <= wr_col_g;
        end
    end

    // Window column c reads buffer entry (offset + c) mod len; past the end
    // of the buffer it is blank unless the pass wraps.
    logic [SUM_W-1:0] len_div;
    assign len_div = (len == '0) ? SUM_W'(1) : SUM_W'(len);

    for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_win
        logic [SUM_W-1:0] sum, wrapped;
        logic [OFS_W-1:0] rd_idx;
        logic             visible;

        assign sum     = SUM_W'(offset) + SUM_W'(c);
        assign wrapped = sum % len_div;
        assign rd_idx  = OFS_W'(wrapped);
        assign visible = (len != '0) && ((sum < SUM_W'(len)) || loop_q);
        assign win_r[c] = visible ? buf_r[rd_idx] : '0;
        assign win_g[c] = visible ? buf_g[rd_idx] : '0;
    end

    for (genvar r = 0; r < MATRIX_DIM; r++) begin : g_row
        for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_col
            assign frame_r[MATRIX_DIM*r + (MATRIX_DIM-1-c)] = win_r[c][r];
            assign frame_g[MATRIX_DIM*r + (MATRIX_DIM-1-c)] = win_g[c][r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len        <= '0;
            offset     <= '0;
            loop_q     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            matrix_r   <= '0;
            matrix_g   <= '0;
        end else begin
            busy       <= (next_state != ST_IDLE);
            frame_done <= enter_hold;

            if (state == ST_IDLE) begin
                len <= len_next;
            end

            if (show_start) begin
                offset <= '0;
                loop_q <= loop;
            end else if (step_advance) begin
                offset <= step_wrap ? '0 : offset + OFS_W'(1);
            end

            matrix_r <= (state == ST_IDLE) ? '0 : frame_r;
            matrix_g <= (state == ST_IDLE) ? '0 : frame_g;
        end
    end

endmodule

// File: tb/tb_matrix_scroller.sv
// -----------------------------------------------------------------------------
// tb_matrix_scroller
// Self-checking bench for matrix_scroller with STEP_DIV = 4. The reference
// model keeps the written columns in queues and derives the expected window
// offset from elapsed clocks with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_matrix_scroller;

    localparam int STEP_DIV = 4;
    localparam int BUF_COLS = 16;

    logic        clk = 1'b0;
    logic        rst, wr_valid, wr_ready, start, loop, stop, clr, busy, frame_done;
    logic [7:0]  wr_col_r, wr_col_g;
    logic [63:0] matrix_r, matrix_g;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] m_r[$];
    logic [7:0] m_g[$];

    matrix_scroller #(
        .STEP_DIV (STEP_DIV),
        .BUF_COLS (BUF_COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_col_r   (wr_col_r),
        .wr_col_g   (wr_col_g),
        .start      (start),
        .loop       (loop),
        .stop       (stop),
        .clr        (clr),
        .busy       (busy),
        .frame_done (frame_done),
        .matrix_r   (matrix_r),
        .matrix_g   (matrix_g)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame for a window starting at buffer column off.
    function automatic logic [63:0] model_frame(input bit green, input int off, input bit lp);
        logic [63:0] f;
        int          len;
        f   = '0;
        len = m_r.size();
        for (int c = 0; c < 8; c++) begin
            int         p;
            logic [7:0] col;
            p = off + c;
            if (len == 0 || (p >= len && !lp)) col = 8'h00;
            else col = green ? m_g[p % len] : m_r[p % len];
            for (int r = 0; r < 8; r++) f[8*r + 7 - c] = col[r];
        end
        return f;
    endfunction

    // Window offset after j clocks of showing.
    function automatic int model_offset(input int j, input bit lp);
        int len, steps;
        len   = m_r.size();
        steps = j / STEP_DIV;
        if (len <= 8) return 0;
        if (lp) return steps % len;
        return (steps < len - 8) ? steps : len - 8;
    endfunction

    task automatic write_col(input logic [7:0] r, input logic [7:0] g);
        bit accept;
        accept   = (m_r.size() < BUF_COLS);
        wr_valid = 1'b1;
        wr_col_r = r;
        wr_col_g = g;
        tick();
        wr_valid = 1'b0;
        if (accept) begin
            m_r.push_back(r);
            m_g.push_back(g);
        end
    endtask

    task automatic write_random(input int n);
        for (int i = 0; i < n; i++) write_col(8'($urandom), 8'($urandom));
    endtask

    task automatic do_start(input bit lp);
        start = 1'b1;
        loop  = lp;
        tick();
        start = 1'b0;
        loop  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_r.delete();
        m_g.delete();
    endtask

    // Called right after the start edge (k = 0); checks every clock up to k_last.
    task automatic run_show(input string tag, input bit lp, input int k_last,
                            input bit from_hold, input int clr_at);
        int len;
        len = m_r.size();
        for (int k = 0; k <= k_last; k++) begin
            logic [63:0] er, eg;
            bit          efd;
            if (k == 0) begin
                er = from_hold ? model_frame(1'b0, len - 8, 1'b0) : 64'h0;
                eg = from_hold ? model_frame(1'b1, len - 8, 1'b0) : 64'h0;
            end else begin
                er = model_frame(1'b0, model_offset(k - 1, lp), lp);
                eg = model_frame(1'b1, model_offset(k - 1, lp), lp);
            end
            efd = !lp && (len > 8) && (k == STEP_DIV * (len - 7));
            n_compared++;
            if (matrix_r !== er || matrix_g !== eg || busy !== 1'b1 || frame_done !== efd) begin
                n_mismatched++;
                $display("FAIL %s k=%0d: matrix_r got %h want %h, matrix_g got %h want %h, busy got %b want 1, frame_done got %b want %b",
                         tag, k, matrix_r, er, matrix_g, eg, busy, frame_done, efd);
            end
            if (k < k_last) begin
                clr = (k == clr_at);
                tick();
                clr = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_compared++;
        if (frame_done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
        n_compared++;
        if (matrix_r !== 64'h0 || matrix_g !== 64'h0) begin
            n_mismatched++;
            $display("FAIL reset_matrix: got %h/%h want 0/0", matrix_r, matrix_g);
        end
        n_compared++;
        if (wr_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
    endtask

    task automatic test_static_image();
        do_clr();
        for (int c = 0; c < 8; c++) write_col(8'(1 << c), 8'($urandom));
        do_start(1'b0);
        run_show("static", 1'b0, 40, 1'b0, -1);
        do_stop();
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL static_stop_busy: got %b want 0", busy);
        end
        tick();
        n_compared++;
        if (matrix_r !== 64'h0 || matrix_g !== 64'h0) begin
            n_mismatched++;
            $display("FAIL static_stop_matrix: got %h/%h want 0/0", matrix_r, matrix_g);
        end
    endtask

    task automatic test_one_shot_and_restart();
        do_clr();
        write_random(10);
        do_start(1'b0);
        run_show("one_shot", 1'b0, STEP_DIV * 3 + 12, 1'b0, -1);
        do_start(1'b0);
        run_show("hold_restart", 1'b0, 6, 1'b1, -1);
        do_stop();
        tick();
    endtask

    task automatic test_loop();
        do_clr();
        write_random(10);
        do_start(1'b1);
        // clr pulsed mid-show must be ignored
        run_show("loop", 1'b1, STEP_DIV * 11 + 2, 1'b0, 5);
        do_stop();
        tick();
        do_start(1'b1);
        run_show("loop_buffer_kept", 1'b1, 3, 1'b0, -1);
        do_stop();
        tick();
    endtask

    task automatic test_full_and_clr();
        do_clr();
        for (int i = 0; i < 17; i++) begin
            bit exp_ready;
            exp_ready = (m_r.size() < BUF_COLS);
            wr_valid  = 1'b1;
            wr_col_r  = 8'($urandom);
            wr_col_g  = 8'($urandom);
            n_compared++;
            if (wr_ready !== exp_ready) begin
                n_mismatched++;
                $display("FAIL full_wr_ready[%0d]: got %b want %b", i, wr_ready, exp_ready);
            end
            tick();
            if (exp_ready) begin
                m_r.push_back(wr_col_r);
                m_g.push_back(wr_col_g);
            end
        end
        wr_valid = 1'b0;
        do_clr();
        do_start(1'b0);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL empty_start_busy: got %b want 0", busy);
        end
        tick();
        n_compared++;
        if (busy !== 1'b0 || matrix_r !== 64'h0) begin
            n_mismatched++;
            $display("FAIL empty_start_idle: busy got %b want 0, matrix_r got %h want 0", busy, matrix_r);
        end
    endtask

    task automatic test_write_with_start();
        do_clr();
        wr_valid = 1'b1;
        wr_col_r = 8'($urandom);
        wr_col_g = 8'($urandom);
        start    = 1'b1;
        loop     = 1'b0;
        tick();
        m_r.push_back(wr_col_r);
        m_g.push_back(wr_col_g);
        wr_valid = 1'b0;
        start    = 1'b0;
        run_show("write_with_start", 1'b0, 6, 1'b0, -1);
        do_stop();
        tick();
    endtask

    task automatic test_stop_on_step();
        logic [63:0] er;
        do_clr();
        write_random(12);
        do_start(1'b1);
        run_show("pre_stop", 1'b1, 2 * STEP_DIV - 1, 1'b0, -1);
        er = model_frame(1'b0, model_offset(2 * STEP_DIV - 1, 1'b1), 1'b1);
        do_stop();
        n_compared++;
        if (busy !== 1'b0 || matrix_r !== er) begin
            n_mismatched++;
            $display("FAIL stop_on_step: busy got %b want 0, matrix_r got %h want %h", busy, matrix_r, er);
        end
        tick();
        n_compared++;
        if (matrix_r !== 64'h0 || matrix_g !== 64'h0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL stop_outputs_zero: got %h/%h busy %b want 0/0 busy 0", matrix_r, matrix_g, busy);
        end
    endtask

    task automatic test_reset_mid_show();
        do_clr();
        write_random(12);
        do_start(1'b1);
        run_show("pre_reset", 1'b1, 9, 1'b0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_r.delete();
        m_g.delete();
        n_compared++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL mid_reset_flags: busy got %b want 0, frame_done got %b want 0", busy, frame_done);
        end
        n_compared++;
        if (matrix_r !== 64'h0 || matrix_g !== 64'h0) begin
            n_mismatched++;
            $display("FAIL mid_reset_matrix: got %h/%h want 0/0", matrix_r, matrix_g);
        end
        n_compared++;
        if (wr_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL mid_reset_wr_ready: got %b want 1", wr_ready);
        end
        do_start(1'b1);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL mid_reset_len: busy got %b want 0 (len must be 0)", busy);
        end
    endtask

    task automatic test_random_shows();
        for (int t = 0; t < 6; t++) begin
            int n;
            bit lp;
            do_clr();
            n  = $urandom_range(1, BUF_COLS);
            lp = 1'($urandom_range(0, 1));
            write_random(n);
            do_start(lp);
            run_show("random", lp, STEP_DIV * (n + 1) + 2, 1'b0, -1);
            do_stop();
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_col_r = 8'h00;
        wr_col_g = 8'h00;
        start    = 1'b0;
        loop     = 1'b0;
        stop     = 1'b0;
        clr      = 1'b0;

        test_reset();
        test_static_image();
        test_one_shot_and_restart();
        test_loop();
        test_full_and_clr();
        test_write_with_start();
        test_stop_on_step();
        test_reset_mid_show();
        test_random_shows();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
